// File: rtl/stage_mem_if.sv
// stage_mem_if: groups the MEM-stage pipeline inputs, the write-back outputs and the
// bytewise memory-controller handshake into one bundle.
//   slave  : the MEM stage itself (pipeline/memory inputs in, write-back/request out)
//   master : whoever drives the stage (pipeline register + memory controller, or a bench)
interface stage_mem_if;
  // Pipeline inputs from EX/MEM
  logic        write_i;
  logic [4:0]  regw_addr_i;
  logic [31:0] regw_data_i;
  logic        load_i;
  logic        store_i;
  logic [2:0]  funct3_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  // Memory controller responses
  logic        mem_ready_i;
  logic [7:0]  mem_rdata_i;
  // Write-back towards MEM/WB
  logic        write_o;
  logic [4:0]  regw_addr_o;
  logic [31:0] regw_data_o;
  logic        stall_req_o;
  // Byte requests towards the memory controller
  logic        mem_req_o;
  logic        mem_rw_o;
  logic [31:0] mem_addr_o;
  logic [7:0]  mem_wdata_o;
  logic        misalign_o;

  modport slave (
    input  write_i, regw_addr_i, regw_data_i, load_i, store_i, funct3_i, addr_i, wdata_i,
           mem_ready_i, mem_rdata_i,
    output write_o, regw_addr_o, regw_data_o, stall_req_o, mem_req_o, mem_rw_o,
           mem_addr_o, mem_wdata_o, misalign_o
  );

  modport master (
    output write_i, regw_addr_i, regw_data_i, load_i, store_i, funct3_i, addr_i, wdata_i,
           mem_ready_i, mem_rdata_i,
    input  write_o, regw_addr_o, regw_data_o, stall_req_o, mem_req_o, mem_rw_o,
           mem_addr_o, mem_wdata_o, misalign_o
  );
endinterface

// File: rtl/stage_mem.sv
// stage_mem: MEM pipeline stage. ALU results pass straight through with zero latency;
// loads and stores are split into 1/2/4 single-byte transfers to a byte-wide memory
// controller while the stage holds the front of the pipeline frozen via stall_req_o.
// Ports:
//   clock  - rising-edge clock
//   reset  - asynchronous active-high reset; forces IDLE and drives every output to 0
//   bus    - stage_mem_if.slave: pipeline inputs, write-back outputs, byte memory port
// Optional feature: define MEM_ALIGN_CHECK_EN to reject misaligned H/W accesses
// (misalign_o=1, no request, no stall). Without it misalign_o is tied to 0.
module stage_mem (
  input  logic        clock,
  input  logic        reset,
  stage_mem_if.slave  bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_t;

  state_t      r_state, w_state_next;
  logic [1:0]  r_k, w_k_next;
  logic [31:0] r_buf, w_buf_next;

  logic        w_mem_op;
  logic [1:0]  w_last_k;
  logic        w_misalign;
  logic [31:0] w_ext;
  logic [4:0]  w_bit_off;

  assign w_mem_op  = bus.load_i | bus.store_i;
  assign w_bit_off = {r_k, 3'b000};

  // Index of the final byte: B/BU -> 0, H/HU -> 1, W and undefined encodings -> 3
  always_comb begin
    case (bus.funct3_i[1:0])
      2'b00:   w_last_k = 2'd0;
      2'b01:   w_last_k = 2'd1;
      default: w_last_k = 2'd3;
    endcase
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign w_misalign = ((w_last_k == 2'd1) && bus.addr_i[0]) ||
                      ((w_last_k == 2'd3) && (bus.addr_i[1:0] != 2'b00));
`else
  assign w_misalign = 1'b0;
`endif

  // Load result extension from the assembled little-endian buffer
  always_comb begin
    case (bus.funct3_i)
      3'b000:  w_ext = {{24{r_buf[7]}}, r_buf[7:0]};
      3'b001:  w_ext = {{16{r_buf[15]}}, r_buf[15:0]};
      3'b100:  w_ext = {24'b0, r_buf[7:0]};
      3'b101:  w_ext = {16'b0, r_buf[15:0]};
      default: w_ext = r_buf;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_k     <= 2'd0;
      r_buf   <= 32'd0;
    end else begin
      r_state <= w_state_next;
      r_k     <= w_k_next;
      r_buf   <= w_buf_next;
    end
  end

  always_comb begin
    w_state_next    = r_state;
    w_k_next        = r_k;
    w_buf_next      = r_buf;
    bus.write_o     = bus.write_i;
    bus.regw_addr_o = bus.regw_addr_i;
    bus.regw_data_o = bus.regw_data_i;
    bus.stall_req_o = 1'b0;
    bus.mem_req_o   = 1'b0;
    bus.mem_rw_o    = 1'b0;
    bus.mem_addr_o  = 32'd0;
    bus.mem_wdata_o = 8'd0;
    bus.misalign_o  = 1'b0;

    case (r_state)
      StIdle: begin
        if (w_mem_op) begin
          bus.write_o = 1'b0;
          if (w_misalign) begin
            // Rejected access: the pipeline keeps moving, nothing is requested
            bus.misalign_o = 1'b1;
          end else begin
            bus.stall_req_o = 1'b1;
            w_k_next        = 2'd0;
            w_buf_next      = 32'd0;
            w_state_next    = StBusy;
          end
        end
      end
      StBusy: begin
        bus.write_o     = 1'b0;
        bus.stall_req_o = 1'b1;
        bus.mem_req_o   = 1'b1;
        bus.mem_rw_o    = bus.store_i;
        bus.mem_addr_o  = bus.addr_i + {30'd0, r_k};
        bus.mem_wdata_o = bus.wdata_i[w_bit_off +: 8];
        if (bus.mem_ready_i) begin
          if (bus.load_i) begin
            w_buf_next[w_bit_off +: 8] = bus.mem_rdata_i;
          end
          if (r_k == w_last_k) begin
            w_state_next = StDone;
          end else begin
            w_k_next = r_k + 2'd1;
          end
        end
      end
      StDone: begin
        // Stall drops here so the pipeline advances on the same edge we return to IDLE
        if (bus.store_i) begin
          bus.write_o = 1'b0;
        end else if (bus.load_i) begin
          bus.regw_data_o = w_ext;
        end
        w_state_next = StIdle;
      end
      default: begin
        w_state_next = StIdle;
      end
    endcase

    if (reset) begin
      bus.write_o     = 1'b0;
      bus.regw_addr_o = 5'd0;
      bus.regw_data_o = 32'd0;
      bus.stall_req_o = 1'b0;
      bus.mem_req_o   = 1'b0;
      bus.mem_rw_o    = 1'b0;
      bus.mem_addr_o  = 32'd0;
      bus.mem_wdata_o = 8'd0;
      bus.misalign_o  = 1'b0;
    end
  end

endmodule

// File: tb/tb_stage_mem.sv
// tb_stage_mem: randomized and directed stimulus for stage_mem. Each instruction is
// expanded up front into the per-cycle output trace it must produce (accept cycle,
// byte transfers with their wait cycles, completion cycle), and one compare step checks
// the DUT against that trace every cycle. Directed cases pin literal expected values.
module tb_stage_mem;
  logic clock = 1'b0;
  logic reset = 1'b1;

  stage_mem_if bus ();

  stage_mem dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        wr;
    logic [4:0]  rd;
    logic [31:0] rdat;
    logic        ld;
    logic        st;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdat;
    logic        rdy;
    logic [7:0]  rbyte;
    logic        e_wr;
    logic        e_chk_rd;
    logic [4:0]  e_rd;
    logic [31:0] e_rdat;
    logic        e_stall;
    logic        e_req;
    logic        e_rw;
    logic [31:0] e_maddr;
    logic [7:0]  e_mwd;
    logic        e_mis;
  } cyc_t;

  cyc_t q[$];

  int checks = 0;
  int failures = 0;
  int cyc_n = 0;

  logic        obs_wr;
  logic        obs_stall;
  logic        obs_mis;
  logic [31:0] obs_data;
  logic [31:0] obs_addr[$];
  logic [7:0]  obs_wd[$];
  logic        obs_rw[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=0x%08h expected=0x%08h", name, cyc_n, act, exp);
    end
  endtask

  task automatic drive(input cyc_t c);
    bus.write_i     = c.wr;
    bus.regw_addr_i = c.rd;
    bus.regw_data_i = c.rdat;
    bus.load_i      = c.ld;
    bus.store_i     = c.st;
    bus.funct3_i    = c.f3;
    bus.addr_i      = c.addr;
    bus.wdata_i     = c.wdat;
    bus.mem_ready_i = c.rdy;
    bus.mem_rdata_i = c.rbyte;
  endtask

  task automatic step(input cyc_t c);
    @(posedge clock);
    #1;
    drive(c);
    @(negedge clock);
    cyc_n++;
    chk("stall_req_o", 32'(bus.stall_req_o), 32'(c.e_stall));
    chk("mem_req_o", 32'(bus.mem_req_o), 32'(c.e_req));
    chk("write_o", 32'(bus.write_o), 32'(c.e_wr));
    chk("misalign_o", 32'(bus.misalign_o), 32'(c.e_mis));
    if (c.e_req) begin
      chk("mem_addr_o", bus.mem_addr_o, c.e_maddr);
      chk("mem_wdata_o", 32'(bus.mem_wdata_o), 32'(c.e_mwd));
      chk("mem_rw_o", 32'(bus.mem_rw_o), 32'(c.e_rw));
    end
    if (c.e_chk_rd) begin
      chk("regw_addr_o", 32'(bus.regw_addr_o), 32'(c.e_rd));
      chk("regw_data_o", bus.regw_data_o, c.e_rdat);
    end
    if (bus.mem_req_o && bus.mem_ready_i) begin
      obs_addr.push_back(bus.mem_addr_o);
      obs_wd.push_back(bus.mem_wdata_o);
      obs_rw.push_back(bus.mem_rw_o);
    end
    obs_wr    = bus.write_o;
    obs_stall = bus.stall_req_o;
    obs_mis   = bus.misalign_o;
    obs_data  = bus.regw_data_o;
  endtask

  // Expand one instruction into its expected cycle trace. dly<0 picks a random wait
  // (0..3 cycles) before each byte's ready; rbytes supplies the bytes memory returns.
  task automatic build_instr(input logic wr, input logic [4:0] rd, input logic [31:0] rdat,
                             input logic ld, input logic st, input logic [2:0] f3,
                             input logic [31:0] addr, input logic [31:0] wdat,
                             input int dly, input logic [31:0] rbytes);
    cyc_t c;
    int n;
    int d;
    logic mis;
    logic [31:0] v;
    n = (f3[1:0] == 2'b00) ? 1 : ((f3[1:0] == 2'b01) ? 2 : 4);
    mis = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    mis = ((n == 2) && addr[0]) || ((n == 4) && (addr[1:0] != 2'b00));
`endif
    c = '{default: '0};
    c.wr = wr; c.rd = rd; c.rdat = rdat; c.ld = ld; c.st = st; c.f3 = f3;
    c.addr = addr; c.wdat = wdat;
    c.rdy = 1'($urandom);
    c.rbyte = 8'($urandom);
    c.e_rd = rd;
    if (!(ld || st)) begin
      c.e_wr = wr; c.e_chk_rd = 1'b1; c.e_rdat = rdat;
      q.push_back(c);
    end else if (mis) begin
      c.e_mis = 1'b1;
      q.push_back(c);
    end else begin
      c.e_stall = 1'b1;
      q.push_back(c);
      for (int j = 0; j < n; j++) begin
        d = (dly < 0) ? int'($urandom_range(3, 0)) : dly;
        for (int w = 0; w <= d; w++) begin
          c.rdy     = (w == d);
          c.rbyte   = (w == d) ? rbytes[8*j +: 8] : 8'($urandom);
          c.e_req   = 1'b1;
          c.e_rw    = st;
          c.e_maddr = addr + 32'(j);
          c.e_mwd   = wdat[8*j +: 8];
          q.push_back(c);
        end
      end
      v = rbytes;
      if (n == 1) v = {24'd0, v[7:0]};
      if (n == 2) v = {16'd0, v[15:0]};
      if (f3 == 3'b000 && v[7]) v = v | 32'hFFFF_FF00;
      if (f3 == 3'b001 && v[15]) v = v | 32'hFFFF_0000;
      c.rdy = 1'($urandom); c.rbyte = 8'($urandom);
      c.e_stall = 1'b0; c.e_req = 1'b0;
      c.e_wr = ld ? wr : 1'b0;
      c.e_chk_rd = ld;
      c.e_rdat = v;
      q.push_back(c);
    end
  endtask

  task automatic run_q();
    obs_addr.delete();
    obs_wd.delete();
    obs_rw.delete();
    while (q.size() > 0) step(q.pop_front());
  endtask

  task automatic do_instr(input logic wr, input logic [4:0] rd, input logic [31:0] rdat,
                          input logic ld, input logic st, input logic [2:0] f3,
                          input logic [31:0] addr, input logic [31:0] wdat,
                          input int dly, input logic [31:0] rbytes);
    build_instr(wr, rd, rdat, ld, st, f3, addr, wdat, dly, rbytes);
    run_q();
  endtask

  task automatic drive_nop();
    cyc_t c;
    c = '{default: '0};
    drive(c);
  endtask

  initial begin
    cyc_t c;
    int kind;
    logic [31:0] a;

    // Reset state: an ALU op on the inputs must not leak through while reset is high
    c = '{default: '0};
    c.wr = 1'b1; c.rd = 5'd9; c.rdat = 32'hDEAD_BEEF; c.ld = 1'b1;
    drive(c);
    #2;
    chk("reset_write_o", 32'(bus.write_o), 32'd0);
    chk("reset_regw_data_o", bus.regw_data_o, 32'd0);
    chk("reset_stall_req_o", 32'(bus.stall_req_o), 32'd0);
    chk("reset_mem_req_o", 32'(bus.mem_req_o), 32'd0);
    drive_nop();
    @(negedge clock);
    reset = 1'b0;

    // ALU passthrough
    do_instr(1'b1, 5'd5, 32'h1234, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 0, 32'h0);
    chk("alu_write_o", 32'(obs_wr), 32'd1);
    chk("alu_regw_data_o", obs_data, 32'h1234);
    chk("alu_stall_req_o", 32'(obs_stall), 32'd0);

    // LW at 0x100, ready every cycle
    do_instr(1'b1, 5'd3, 32'h0, 1'b1, 1'b0, 3'b010, 32'h100, 32'h0, 0, 32'h1234_5678);
    chk("lw_data", obs_data, 32'h1234_5678);
    chk("lw_nreq", 32'(obs_addr.size()), 32'd4);
    if (obs_addr.size() == 4) begin
      chk("lw_addr0", obs_addr[0], 32'h100);
      chk("lw_addr3", obs_addr[3], 32'h103);
    end
    chk("lw_stall_done", 32'(obs_stall), 32'd0);

    // LB / LBU with byte 0x80
    do_instr(1'b1, 5'd4, 32'h0, 1'b1, 1'b0, 3'b000, 32'h7, 32'h0, 1, 32'h0000_0080);
    chk("lb_data", obs_data, 32'hFFFF_FF80);
    do_instr(1'b1, 5'd4, 32'h0, 1'b1, 1'b0, 3'b100, 32'h7, 32'h0, 1, 32'h0000_0080);
    chk("lbu_data", obs_data, 32'h0000_0080);

    // SH at 0x20, 3 wait cycles per byte
    do_instr(1'b1, 5'd6, 32'h0, 1'b0, 1'b1, 3'b001, 32'h20, 32'h0000_ABCD, 3, 32'h0);
    chk("sh_nreq", 32'(obs_wd.size()), 32'd2);
    if (obs_wd.size() == 2) begin
      chk("sh_wdata0", 32'(obs_wd[0]), 32'h0000_00CD);
      chk("sh_wdata1", 32'(obs_wd[1]), 32'h0000_00AB);
      chk("sh_rw", 32'(obs_rw[1]), 32'd1);
    end
    chk("sh_write_o", 32'(obs_wr), 32'd0);

    // Reset during byte 2 of an LW: stop after the first wait cycle of byte 2
    build_instr(1'b1, 5'd7, 32'h0, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 2, 32'hCAFE_F00D);
    obs_addr.delete(); obs_wd.delete(); obs_rw.delete();
    for (int i = 0; i < 8; i++) step(q.pop_front());
    q.delete();
    chk("pre_reset_req", 32'(bus.mem_req_o), 32'd1);
    #1;
    reset = 1'b1;
    #1;
    chk("async_reset_mem_req_o", 32'(bus.mem_req_o), 32'd0);
    chk("async_reset_stall_req_o", 32'(bus.stall_req_o), 32'd0);
    chk("async_reset_write_o", 32'(bus.write_o), 32'd0);
    drive_nop();
    @(negedge clock);
    reset = 1'b0;
    do_instr(1'b1, 5'd7, 32'h0, 1'b1, 1'b0, 3'b010, 32'h300, 32'h0, 0, 32'hCAFE_F00D);
    if (obs_addr.size() > 0) chk("restart_addr0", obs_addr[0], 32'h300);
    else chk("restart_nreq", 32'(obs_addr.size()), 32'd4);
    chk("restart_data", obs_data, 32'hCAFE_F00D);

    // LW at 0x102
    do_instr(1'b1, 5'd8, 32'h0, 1'b1, 1'b0, 3'b010, 32'h102, 32'h0, 0, 32'h0102_0304);
`ifdef MEM_ALIGN_CHECK_EN
    chk("mis_flag", 32'(obs_mis), 32'd1);
    chk("mis_nreq", 32'(obs_addr.size()), 32'd0);
`else
    chk("mis_flag", 32'(obs_mis), 32'd0);
    chk("mis_nreq", 32'(obs_addr.size()), 32'd4);
    if (obs_addr.size() == 4) begin
      chk("mis_addr0", obs_addr[0], 32'h102);
      chk("mis_addr3", obs_addr[3], 32'h105);
    end
    chk("mis_data", obs_data, 32'h0102_0304);
`endif

    // Randomized mix, back-to-back, including addresses near the 32-bit wrap
    for (int i = 0; i < 300; i++) begin
      kind = int'($urandom_range(3, 0));
      a = ($urandom_range(3, 0) == 0) ? (32'hFFFF_FFFC | 32'($urandom_range(3, 0)))
                                       : $urandom;
      do_instr(1'($urandom), 5'($urandom), $urandom, kind == 1, kind == 2, 3'($urandom),
               a, $urandom, -1, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
